icache_2way_param: RTL and testbench

- Parametrised 2-way set-associative instruction cache. It is the next generation of the direct-mapped memory_hierarchy cache and sits between the fetch stage and the instruction ROM/backing memory.
- Adds configurable geometry, multi-word line refill over a ready-handshake memory port, LRU replacement, flush, and hit/miss counters.
- Read-only: the fetch side never writes.

---
 rtl/icache_2way_param.sv | 186 ++++++++++++++++++
 tb/tb_icache_2way_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_2way_param.sv
// 2-way set-associative read-only instruction cache with multi-word line
// refill over a ready-handshake memory port, per-set LRU, flush and
// saturating hit/miss counters.
module icache_2way_param #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned SETS           = 4,
   parameter int unsigned WORDS_PER_LINE = 2,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic              flush,
   output logic              rd_ready,
   output logic [DATA_W-1:0] inst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int unsigned IndexW  = $clog2(SETS);
   localparam int unsigned OffsetW = $clog2(WORDS_PER_LINE);
   localparam int unsigned TagW    = ADDR_W - IndexW - OffsetW;
   localparam logic [OffsetW-1:0] LastBeat = OffsetW'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {StIdle, StLookup, StRefill, StDone, StFlush} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [OffsetW-1:0]  beat_q, beat_d;
   logic                victim_q, victim_d;
   logic                rd_ready_q, rd_ready_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic                flush_pending_q, flush_pending_d;
   logic [CNT_W-1:0]    hit_count_q, hit_count_d;
   logic [CNT_W-1:0]    miss_count_q, miss_count_d;
   logic [1:0]          valid_q [SETS];
   logic [1:0]          valid_d [SETS];
   logic [TagW-1:0]     tag_q [SETS][2];
   logic [TagW-1:0]     tag_d [SETS][2];
   logic [SETS-1:0]     lru_q, lru_d;
   logic [DATA_W-1:0]   data_q [SETS][2][WORDS_PER_LINE];
   logic                data_we;

   logic [TagW-1:0]     addr_tag;
   logic [IndexW-1:0]   addr_index;
   logic [OffsetW-1:0]  addr_offset;
   logic [1:0]          hit_way;

   assign addr_tag    = addr_q[ADDR_W-1 -: TagW];
   assign addr_index  = addr_q[OffsetW +: IndexW];
   assign addr_offset = addr_q[OffsetW-1:0];

   // Tag compare of both ways in the latched set
   always_comb begin
      hit_way = 2'b00;
      for (int w = 0; w < 2; w++) begin
         hit_way[w] = valid_q[addr_index][w] && (tag_q[addr_index][w] == addr_tag);
      end
   end

   // Next-state logic: FSM, tag/valid/LRU updates and counters
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      beat_d          = beat_q;
      victim_d        = victim_q;
      rd_ready_d      = rd_ready_q;
      inst_d          = inst_q;
      hit_count_d     = hit_count_q;
      miss_count_d    = miss_count_q;
      valid_d         = valid_q;
      tag_d           = tag_q;
      lru_d           = lru_q;
      data_we         = 1'b0;
      // A flush seen in any busy state is remembered until the next idle
      flush_pending_d = flush_pending_q | flush;

      unique case (state_q)
         StIdle: begin
            if (flush || flush_pending_q) begin
               state_d = StFlush;
            end else if (read_enable) begin
               addr_d  = address;
               state_d = StLookup;
            end
         end
         StFlush: begin
            for (int s = 0; s < SETS; s++) begin
               valid_d[s] = 2'b00;
            end
            lru_d           = '0;
            flush_pending_d = 1'b0;
            state_d         = StIdle;
         end
         StLookup: begin
            if (|hit_way) begin
               inst_d                = data_q[addr_index][hit_way[1]][addr_offset];
               rd_ready_d            = 1'b1;
               lru_d[addr_index]     = ~hit_way[1];
               if (hit_count_q != {CNT_W{1'b1}}) hit_count_d = hit_count_q + 1'b1;
               state_d               = StDone;
            end else begin
               if (!valid_q[addr_index][0])      victim_d = 1'b0;
               else if (!valid_q[addr_index][1]) victim_d = 1'b1;
               else                              victim_d = lru_q[addr_index];
               // Victim is invalid while refilling so an aborted refill leaves no stale hit
               valid_d[addr_index][victim_d] = 1'b0;
               if (miss_count_q != {CNT_W{1'b1}}) miss_count_d = miss_count_q + 1'b1;
               beat_d  = '0;
               state_d = StRefill;
            end
         end
         StRefill: begin
            if (mem_ready) begin
               data_we = 1'b1;
               if (beat_q == addr_offset) inst_d = mem_rdata;
               beat_d = beat_q + 1'b1;
               if (beat_q == LastBeat) begin
                  valid_d[addr_index][victim_q] = 1'b1;
                  tag_d[addr_index][victim_q]   = addr_tag;
                  lru_d[addr_index]             = ~victim_q;
                  rd_ready_d                    = 1'b1;
                  state_d                       = StDone;
               end
            end
         end
         StDone: begin
            if (!read_enable) begin
               rd_ready_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and tag state, asynchronously cleared
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         beat_q          <= '0;
         victim_q        <= 1'b0;
         rd_ready_q      <= 1'b0;
         inst_q          <= '0;
         flush_pending_q <= 1'b0;
         hit_count_q     <= '0;
         miss_count_q    <= '0;
         valid_q         <= '{default: '0};
         tag_q           <= '{default: '0};
         lru_q           <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         beat_q          <= beat_d;
         victim_q        <= victim_d;
         rd_ready_q      <= rd_ready_d;
         inst_q          <= inst_d;
         flush_pending_q <= flush_pending_d;
         hit_count_q     <= hit_count_d;
         miss_count_q    <= miss_count_d;
         valid_q         <= valid_d;
         tag_q           <= tag_d;
         lru_q           <= lru_d;
      end
   end

   // Line data store; contents are qualified by the valid bits, so no reset
   always_ff @(posedge clock) begin
      if (data_we) data_q[addr_index][victim_q][beat_q] <= mem_rdata;
   end

   assign mem_req    = (state_q == StRefill);
   assign mem_addr   = mem_req ? {addr_tag, addr_index, beat_q} : '0;
   assign rd_ready   = rd_ready_q;
   assign inst       = inst_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_2way_param.sv
// Bench for icache_2way_param: table of reads with expected data, hit/miss
// and latency, scoreboard queue for returned instructions, memory model
// with optional wait states, and a hand-written reset-mid-refill sequence.
module tb_icache_2way_param;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;
   localparam int WPL    = 2;

   logic              clock       = 1'b0;
   logic              reset       = 1'b0;
   logic              read_enable = 1'b0;
   logic [ADDR_W-1:0] address     = '0;
   logic              flush       = 1'b0;
   logic              rd_ready;
   logic [DATA_W-1:0] inst;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   icache_2way_param dut (
      .clock      (clock),
      .reset      (reset),
      .read_enable(read_enable),
      .address    (address),
      .flush      (flush),
      .rd_ready   (rd_ready),
      .inst       (inst),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model: data is {A5, address}; optional 3 wait cycles per beat
   logic              wait_mode = 1'b0;
   logic              rdy_q     = 1'b1;
   int                wcnt      = 0;
   logic              prev_req  = 1'b0;
   logic              prev_rdy  = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   int                beats     = 0;
   logic [ADDR_W-1:0] addr_log[$];

   assign mem_rdata = {8'hA5, mem_addr};
   assign mem_ready = mem_req && rdy_q;

   // Decide readiness for the coming edge and log beats that will be taken
   always @(negedge clock) begin
      if (!reset || !mem_req) begin
         wcnt     = 0;
         prev_req = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (prev_req && !prev_rdy) check("mem_addr_hold", 32'(mem_addr), 32'(prev_addr));
         wcnt      = prev_rdy ? 1 : wcnt + 1;
         prev_req  = 1'b1;
         prev_addr = mem_addr;
      end
      rdy_q = !wait_mode || (wcnt == 4);
      if (reset && mem_req && rdy_q) begin
         beats++;
         addr_log.push_back(mem_addr);
      end
      prev_rdy = reset && mem_req && rdy_q;
   end

   typedef struct {
      bit          rst;   // pulse reset before this read
      int          fl_at; // cycle to pulse flush (-1 none, 0 with request)
      bit          wt;    // wait-state memory
      logic [7:0]  addr;
      logic [15:0] inst;
      bit          hit;
      int          lat;   // cycles from request to rd_ready
   } vec_t;

   typedef struct {
      logic [15:0] inst;
      bit          hit;
   } exp_t;

   exp_t sb[$];
   int   exp_hits   = 0;
   int   exp_misses = 0;

   task automatic apply_reset();
      @(negedge clock);
      reset       = 1'b0;
      read_enable = 1'b0;
      flush       = 1'b0;
      @(negedge clock);
      reset      = 1'b1;
      exp_hits   = 0;
      exp_misses = 0;
      sb.delete();
      addr_log.delete();
   endtask

   task automatic do_read(input vec_t v);
      int           cyc;
      int           b0;
      exp_t         e;
      logic [7:0]   a;
      if (v.rst) apply_reset();
      wait_mode   = v.wt;
      b0          = beats;
      read_enable = 1'b1;
      address     = v.addr;
      flush       = (v.fl_at == 0);
      sb.push_back('{inst: v.inst, hit: v.hit});
      cyc = 0;
      while (!rd_ready && cyc < 100) begin
         @(negedge clock);
         cyc++;
         flush = (cyc == v.fl_at);
      end
      flush = 1'b0;
      if (!rd_ready) begin
         check("rd_ready_timeout", 32'(rd_ready), 32'd1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check("inst", 32'(inst), 32'(e.inst));
         if (v.lat > 0) check("latency", 32'(cyc), 32'(v.lat));
         if (e.hit) exp_hits++;
         else       exp_misses++;
         check("hit_count", 32'(hit_count), 32'(exp_hits));
         check("miss_count", 32'(miss_count), 32'(exp_misses));
         check("refill_beats", 32'(beats - b0), e.hit ? 32'd0 : 32'(WPL));
         if (e.hit) begin
            check("no_mem_req_on_hit", 32'(addr_log.size()), 32'd0);
         end else begin
            for (int i = 0; i < WPL; i++) begin
               a = {v.addr[7:1], 1'b0} + 8'(i);
               if (addr_log.size() > 0) check("mem_addr_seq", 32'(addr_log.pop_front()), 32'(a));
               else                     check("mem_addr_seq_missing", 32'd0, 32'(a));
            end
         end
         addr_log.delete();
         // Address changes while holding the request must not disturb the result
         address = ~v.addr;
         @(negedge clock);
         check("done_rd_ready_held", 32'(rd_ready), 32'd1);
         check("done_inst_held", 32'(inst), 32'(e.inst));
      end
      read_enable = 1'b0;
      @(negedge clock);
      check("rd_ready_drop", 32'(rd_ready), 32'd0);
   endtask

   vec_t vecs[11];

   initial begin
      int cyc;
      vecs[0]  = '{0, -1, 0, 8'h02, 16'hA502, 0, 4};
      vecs[1]  = '{0, -1, 0, 8'h03, 16'hA503, 1, 2};
      vecs[2]  = '{1, -1, 0, 8'h02, 16'hA502, 0, 4};
      vecs[3]  = '{0, -1, 0, 8'h0A, 16'hA50A, 0, 4};
      vecs[4]  = '{0, -1, 0, 8'h02, 16'hA502, 1, 2};
      vecs[5]  = '{0, -1, 0, 8'h12, 16'hA512, 0, 4};
      vecs[6]  = '{0, -1, 0, 8'h02, 16'hA502, 1, 2};
      vecs[7]  = '{0, -1, 0, 8'h0A, 16'hA50A, 0, 4};
      vecs[8]  = '{0,  0, 0, 8'h02, 16'hA502, 0, 6};  // flush with request
      vecs[9]  = '{0,  3, 1, 8'h05, 16'hA505, 0, 10}; // wait states, flush mid-refill
      vecs[10] = '{0, -1, 0, 8'h05, 16'hA505, 0, 6};  // pending flush runs first

      // Reset values with no clock edge yet
      #2;
      check("reset_rd_ready", 32'(rd_ready), 32'd0);
      check("reset_inst", 32'(inst), 32'd0);
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      check("reset_hit_count", 32'(hit_count), 32'd0);
      check("reset_miss_count", 32'(miss_count), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) do_read(vecs[i]);

      // Reset in the middle of a refill aborts it immediately
      read_enable = 1'b1;
      address     = 8'h02;
      cyc = 0;
      while (!mem_req && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      check("midrefill_mem_req_seen", 32'(mem_req), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("async_reset_mem_req", 32'(mem_req), 32'd0);
      check("async_reset_rd_ready", 32'(rd_ready), 32'd0);
      check("async_reset_mem_addr", 32'(mem_addr), 32'd0);
      check("async_reset_miss_count", 32'(miss_count), 32'd0);
      read_enable = 1'b0;
      @(negedge clock);
      reset      = 1'b1;
      exp_hits   = 0;
      exp_misses = 0;
      addr_log.delete();
      do_read('{0, -1, 0, 8'h02, 16'hA502, 0, 4});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
